// File: rtl/s_16bit_pkg.sv
// s_16bit_unfold shared types and widths.
// Holds the byte/word widths and the unfold FSM state type.
package s_16bit_pkg;

  localparam int HALF_W = 8;
  localparam int FULL_W = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EMIT_A = 2'd1,
    EMIT_B = 2'd2
  } state_t;

endpackage

// File: rtl/s_16bit_unfold_lane.sv
// s_16bit_unfold_lane: folded byte + low byte -> 16-bit word.
// Upper byte is recovered as folded ^ low.
module s_16bit_unfold_lane
  import s_16bit_pkg::*;
(
  input  logic [HALF_W-1:0] fold,
  input  logic [HALF_W-1:0] lo,
  output logic [FULL_W-1:0] word
);

  // rebuild the word from its xor-folded form
  always_comb begin
    word = {fold ^ lo, lo};
  end

endmodule

// File: rtl/s_16bit_unfold.sv
// s_16bit_unfold: emits words a then b from one folded record.
// Optional macro S_16BIT_UNFOLD_PARITY_CHECK_EN adds in_par/out_err.
module s_16bit_unfold
  import s_16bit_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [HALF_W-1:0] in_aa,
  input  logic [HALF_W-1:0] in_bb,
  input  logic [HALF_W-1:0] in_alo,
  input  logic [HALF_W-1:0] in_blo,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sel,
  output logic [FULL_W-1:0] out_data,
  output logic [7:0]        out_cnt
`ifdef S_16BIT_UNFOLD_PARITY_CHECK_EN
  ,
  input  logic [1:0]        in_par,
  output logic              out_err
`endif
);

  state_t            state;
  logic [HALF_W-1:0] cap_aa;
  logic [HALF_W-1:0] cap_bb;
  logic [HALF_W-1:0] cap_alo;
  logic [HALF_W-1:0] cap_blo;
  logic [HALF_W-1:0] lane_fold;
  logic [HALF_W-1:0] lane_lo;
  logic              in_xfer;
  logic              out_xfer;
`ifdef S_16BIT_UNFOLD_PARITY_CHECK_EN
  logic [1:0]        cap_par;
`endif

  // accept in IDLE, or in EMIT_B when word b leaves this cycle
  always_comb begin
    in_ready = (state == IDLE) ||
               ((state == EMIT_B) && out_ready);
    in_xfer  = in_valid && in_ready;
    out_xfer = out_valid && out_ready;
  end

  // one shared lane, steered by the registered select
  always_comb begin
    lane_fold = out_sel ? cap_bb  : cap_aa;
    lane_lo   = out_sel ? cap_blo : cap_alo;
  end

  s_16bit_unfold_lane u_lane (
    .fold (lane_fold),
    .lo   (lane_lo),
    .word (out_data)
  );

`ifdef S_16BIT_UNFOLD_PARITY_CHECK_EN
  // flag a word whose parity disagrees with the captured bit
  always_comb begin
    out_err = (^out_data) ^ (out_sel ? cap_par[1] : cap_par[0]);
  end
`endif

  // capture registers move only on an accepted record
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_aa  <= '0;
      cap_bb  <= '0;
      cap_alo <= '0;
      cap_blo <= '0;
`ifdef S_16BIT_UNFOLD_PARITY_CHECK_EN
      cap_par <= '0;
`endif
    end else if (in_xfer) begin
      cap_aa  <= in_aa;
      cap_bb  <= in_bb;
      cap_alo <= in_alo;
      cap_blo <= in_blo;
`ifdef S_16BIT_UNFOLD_PARITY_CHECK_EN
      cap_par <= in_par;
`endif
    end
  end

  // sequencing FSM with registered valid/select/count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_sel   <= 1'b0;
      out_cnt   <= '0;
    end else begin
      if (out_xfer) out_cnt <= out_cnt + 8'd1;
      case (state)
        IDLE: begin
          if (in_xfer) begin
            state     <= EMIT_A;
            out_valid <= 1'b1;
            out_sel   <= 1'b0;
          end
        end
        EMIT_A: begin
          if (out_xfer) begin
            state   <= EMIT_B;
            out_sel <= 1'b1;
          end
        end
        EMIT_B: begin
          if (out_xfer) begin
            out_sel <= 1'b0;
            if (in_xfer) begin
              state     <= EMIT_A;
              out_valid <= 1'b1;
            end else begin
              state     <= IDLE;
              out_valid <= 1'b0;
            end
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          out_sel   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_s_16bit_unfold.sv
// tb_s_16bit_unfold: directed + random checks of s_16bit_unfold.
// Reference is a queue of pending words built from 16-bit a/b.
module tb_s_16bit_unfold;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_aa;
  logic [7:0]  in_bb;
  logic [7:0]  in_alo;
  logic [7:0]  in_blo;
  logic        out_valid;
  logic        out_ready;
  logic        out_sel;
  logic [15:0] out_data;
  logic [7:0]  out_cnt;
`ifdef S_16BIT_UNFOLD_PARITY_CHECK_EN
  logic [1:0]  in_par;
  logic        out_err;
`endif

  s_16bit_unfold dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_aa     (in_aa),
    .in_bb     (in_bb),
    .in_alo    (in_alo),
    .in_blo    (in_blo),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sel   (out_sel),
    .out_data  (out_data),
    .out_cnt   (out_cnt)
`ifdef S_16BIT_UNFOLD_PARITY_CHECK_EN
    ,
    .in_par    (in_par),
    .out_err   (out_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        sel;
    logic [15:0] d;
    logic        p;
  } wd_t;

  wd_t         q[$];
  int          checks = 0;
  int          errors = 0;
  int          m_cnt  = 0;
  logic [15:0] cur_a;
  logic [15:0] cur_b;
  logic [1:0]  cur_p;
  logic        got;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic new_rec();
    cur_a = 16'($urandom);
    cur_b = 16'($urandom);
    cur_p = 2'($urandom);
  endtask

  // called just after a falling edge; ends just after the next one
  task automatic cycle(input logic iv, input logic ordy);
    logic e_ready;
    logic ox;
    logic ix;
    wd_t  w;
    in_valid  = iv;
    out_ready = ordy;
    in_aa     = cur_a[7:0] ^ cur_a[15:8];
    in_bb     = cur_b[7:0] ^ cur_b[15:8];
    in_alo    = cur_a[7:0];
    in_blo    = cur_b[7:0];
`ifdef S_16BIT_UNFOLD_PARITY_CHECK_EN
    in_par    = cur_p;
`endif
    #1;
    e_ready = (q.size() == 0) || (q.size() == 1 && ordy);
    chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
    chk("in_ready", 32'(in_ready), 32'(e_ready));
    chk("out_cnt", 32'(out_cnt), 32'(m_cnt));
    if (q.size() != 0) begin
      w = q[0];
      chk("out_data", 32'(out_data), 32'(w.d));
      chk("out_sel", 32'(out_sel), 32'(w.sel));
`ifdef S_16BIT_UNFOLD_PARITY_CHECK_EN
      chk("out_err", 32'(out_err), 32'((^w.d) != w.p));
`endif
    end
    ox = (q.size() != 0) && ordy;
    ix = iv && e_ready;
    if (ox) begin
      void'(q.pop_front());
      m_cnt = (m_cnt + 1) % 256;
    end
    got = ix;
    if (ix) begin
      q.push_back('{sel: 1'b0, d: cur_a, p: cur_p[0]});
      q.push_back('{sel: 1'b1, d: cur_b, p: cur_p[1]});
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 10 && q.size() != 0; i++) cycle(1'b0, 1'b1);
    chk("drained", 32'(q.size()), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    cur_a = '0;
    cur_b = '0;
    cur_p = '0;
    got = 1'b0;
    in_aa = '0; in_bb = '0; in_alo = '0; in_blo = '0;
`ifdef S_16BIT_UNFOLD_PARITY_CHECK_EN
    in_par = '0;
`endif
    @(negedge clk);
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_sel", 32'(out_sel), 32'd0);
    chk("rst_data", 32'(out_data), 32'h0);
    chk("rst_cnt", 32'(out_cnt), 32'd0);
`ifdef S_16BIT_UNFOLD_PARITY_CHECK_EN
    chk("rst_err", 32'(out_err), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // scenario 1: a=0xF00F, b=0x5A5A
    cur_a = 16'hF00F;
    cur_b = 16'h5A5A;
    cur_p = 2'b00;
    cycle(1'b1, 1'b1);
    chk("s1_a", 32'(out_data), 32'hF00F);
    cycle(1'b0, 1'b1);
    chk("s1_b", 32'(out_data), 32'h5A5A);
    chk("s1_bsel", 32'(out_sel), 32'd1);
    cycle(1'b0, 1'b1);
    chk("s1_cnt", 32'(out_cnt), 32'd2);

    // scenario 2: stall in EMIT_A, offered input must be ignored
    cycle(1'b1, 1'b1);
    new_rec();
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 1'b0);
      chk("s2_hold", 32'(out_data), 32'hF00F);
    end
    chk("s2_cnt", 32'(out_cnt), 32'd2);
    drain();

    // scenario 3: back-to-back records, no bubble
    new_rec();
    cycle(1'b1, 1'b1);
    new_rec();
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b1);
      if (got) new_rec();
    end
    chk("s3_cnt", 32'(out_cnt), 32'd8);
    drain();

    // scenario 5: reset in EMIT_A drops the pending record
    new_rec();
    cycle(1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("s5_valid", 32'(out_valid), 32'd0);
    chk("s5_ready", 32'(in_ready), 32'd1);
    chk("s5_cnt", 32'(out_cnt), 32'd0);
    q.delete();
    m_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1);

    // scenario 4: 128 records streamed, count wraps to 0
    begin
      int recs;
      recs = 0;
      new_rec();
      for (int i = 0; i < 400 && recs < 128; i++) begin
        cycle(1'b1, 1'b1);
        if (got) begin
          recs++;
          new_rec();
        end
      end
      chk("s4_recs", 32'(recs), 32'd128);
      drain();
      chk("s4_wrap", 32'(out_cnt), 32'd0);
    end

`ifdef S_16BIT_UNFOLD_PARITY_CHECK_EN
    // scenario 6: a=0x0100 has odd parity
    cur_a = 16'h0100;
    cur_b = 16'h0000;
    cur_p = 2'b00;
    cycle(1'b1, 1'b0);
    chk("s6_err1", 32'(out_err), 32'd1);
    drain();
    cur_p = 2'b01;
    cycle(1'b1, 1'b0);
    chk("s6_err0", 32'(out_err), 32'd0);
    drain();
`endif

    // random valid/ready traffic
    new_rec();
    for (int i = 0; i < 600; i++) begin
      cycle(1'($urandom), 1'($urandom_range(0, 3) != 0));
      if (got) new_rec();
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/s_16bit_unfold.md
S_16BIT_UNFOLD -- requirements
Module: s_16bit_unfold

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 in_valid  input  1  input record present.
REQ-005 in_ready  output  1  block accepts the input record this cycle.
REQ-006 in_aa  input  8  folded a byte, equal to a[7:0]^a[15:8].
REQ-007 in_bb  input  8  folded b byte, equal to b[7:0]^b[15:8].
REQ-008 in_alo  input  8  original a[7:0].
REQ-009 in_blo  input  8  original b[7:0].
REQ-010 out_valid  output  1  out_data is valid.
REQ-011 out_ready  input  1  downstream consumes the output this cycle.
REQ-012 out_sel  output  1  0 = word a, 1 = word b.
REQ-013 out_data  output  16  reconstructed 16-bit word.
REQ-014 out_cnt  output  8  number of words emitted, modulo 256.

Function
REQ-015 An input transfer SHALL occur when in_valid and in_ready are both 1; an output transfer SHALL occur when out_valid and out_ready are both 1.
REQ-016 The FSM SHALL have three states: IDLE, EMIT_A, EMIT_B.
REQ-017 IDLE: out_valid=0 and in_ready=1. An input transfer SHALL capture all four inputs and move the FSM to EMIT_A.
REQ-018 EMIT_A: out_valid=1, out_sel=0, out_data={cap_aa^cap_alo, cap_alo}, in_ready=0. An output transfer SHALL move the FSM to EMIT_B.
REQ-019 EMIT_B: out_valid=1, out_sel=1, out_data={cap_bb^cap_blo, cap_blo}, in_ready=out_ready. An output transfer SHALL move the FSM to EMIT_A if an input transfer happens in the same cycle, and to IDLE otherwise.
REQ-020 Latency from the input-transfer edge to out_valid=1 SHALL be one cycle. Sustained throughput SHALL be one record per two cycles when out_ready is held at 1.
REQ-021 While out_valid=1 and out_ready=0, out_data and out_sel SHALL stay stable and no input SHALL be accepted.
REQ-022 out_cnt SHALL increment by 1 on every output transfer and wrap from 255 to 0.
REQ-023 in_valid with in_ready=0 SHALL have no effect; captured registers SHALL change only on an input transfer.

Reset
REQ-024 When rst_n=0, the block SHALL asynchronously force: FSM=IDLE, out_valid=0, in_ready=1, out_sel=0, out_data=0x0000, out_cnt=0, all capture registers=0.
REQ-025 A reset that arrives mid-record SHALL discard the pending record; after reset release, no stale word SHALL be emitted.

Configuration
REQ-026 With macro S_16BIT_UNFOLD_PARITY_CHECK_EN defined, the block SHALL add two ports: input in_par[1:0], which carries the expected even parity of words a and b and is captured with the record, and output out_err, which is 1 when the XOR-reduction of out_data differs from the captured parity bit selected by out_sel. out_err SHALL reset to 0.
REQ-027 Without S_16BIT_UNFOLD_PARITY_CHECK_EN, in_par and out_err SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-028 Shared package s_16bit_pkg SHALL hold HALF_W=8, FULL_W=16, and the FSM state enum type.
REQ-029 Sub-module s_16bit_unfold_lane SHALL implement the combinational reconstruction (folded byte, low byte) -> 16-bit word. It SHALL be instantiated once and muxed by state.

Verification
REQ-030 Scenario 1: in_aa=0xFF, in_alo=0x0F, in_bb=0x00, in_blo=0x5A, out_ready=1 -> 0xF00F with sel=0, then 0x5A5A with sel=1, on consecutive cycles; out_cnt=2.
REQ-031 Scenario 2: out_ready held at 0 for 5 cycles in EMIT_A -> out_data stays 0xF00F, in_ready=0, out_cnt unchanged.
REQ-032 Scenario 3: back-to-back records with in_valid=1 and out_ready=1 -> in_ready=1 in every EMIT_B cycle, no bubble, four words in four cycles.
REQ-033 Scenario 4: 128 records (256 words) -> out_cnt wraps to 0x00 after the final transfer.
REQ-034 Scenario 5: rst_n asserted in EMIT_A -> out_valid=0 immediately; after release, IDLE and in_ready=1, and no word is emitted.
REQ-035 Scenario 6 (macro defined): in_aa=0x01 with in_par[0]=0 -> out_err=1 with word a; with in_par[0]=1 -> out_err=0.
